// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, slave state type and byte-lane helper
//
// Purpose: encodings and helpers shared by the image-memory AHB slave.
// Contents: HTRANS/HSIZE/HRESP encodings, slave_state_t, byte_enable().

package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

  // Little-endian lane mask; callers only pass legal size/alignment pairs.
  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_img_mem_array.sv
// rtl/ahb_img_mem_array.sv - 2^ADDR_W x 32 RAM with byte-write enables and registered read
//
// Purpose: storage for the image memory. Writes commit per byte lane on the
//          clock edge; reads are registered and return the pre-write contents
//          when the same word is written on the same edge.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (read register only)
//   wr_addr  word address of the write
//   wr_be    byte-lane write enables (0 = no write)
//   wr_data  write data
//   rd_en    load the read register this edge
//   rd_addr  word address of the read
//   rd_data  registered read data

module ahb_img_mem_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_be,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ahb_img_mem.sv
// rtl/ahb_img_mem.sv - AHB slave image memory with wait states, byte lanes and ERROR responses
//
// Purpose: AHB responder for the rotation engine DMA. Decodes the address
//          phase, inserts WAIT_STATES wait cycles per OKAY beat, gives a
//          two-cycle ERROR for out-of-range / bad-size / misaligned beats and
//          forwards a same-edge write into a read of the same word.
// Option:  AHB_IMG_MEM_SEQ_FAST_EN - SEQ beats after an OKAY beat skip WAIT.
// Ports:
//   I_HCLK, I_HRESET (sync, active-high)
//   I_MEM_HSEL, I_MEM_HADDR, I_MEM_HTRANS, I_MEM_HSIZE, I_MEM_HBURST (ignored),
//   I_MEM_HWRITE, I_MEM_HWDATA                      - AHB slave inputs
//   O_MEM_HRDATA, O_MEM_HREADY, O_MEM_HRESP          - AHB slave outputs

module ahb_img_mem
  import ahb_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        I_HCLK,
  input  logic        I_HRESET,
  input  logic        I_MEM_HSEL,
  input  logic [31:0] I_MEM_HADDR,
  input  logic [1:0]  I_MEM_HTRANS,
  input  logic [2:0]  I_MEM_HSIZE,
  input  logic [2:0]  I_MEM_HBURST,
  input  logic        I_MEM_HWRITE,
  input  logic [31:0] I_MEM_HWDATA,
  output logic [31:0] O_MEM_HRDATA,
  output logic        O_MEM_HREADY,
  output logic [1:0]  O_MEM_HRESP
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("ahb_img_mem: WAIT_STATES must be in 0..15");
  end

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  slave_state_t      state, state_nxt;
  logic [3:0]        wait_cnt, cnt_nxt;
  logic              pend_write;
  logic [ADDR_W-1:0] pend_addr;
  logic [3:0]        pend_be;
  logic [3:0]        fwd_mask;
  logic [31:0]       fwd_data;
  logic [31:0]       arr_rdata;
  logic [3:0]        wr_be;
  logic              accept, req_err, addr_ok, size_ok, align_ok, skip_wait;
  logic              fetch_from_bus, rd_is_read, rd_en;
  logic [ADDR_W-1:0] bus_word, rd_addr;
  logic              unused_burst;

  assign unused_burst = ^I_MEM_HBURST;

  assign accept   = O_MEM_HREADY && I_MEM_HSEL &&
                    (I_MEM_HTRANS == HTRANS_NONSEQ || I_MEM_HTRANS == HTRANS_SEQ);
  assign bus_word = I_MEM_HADDR[ADDR_W+1:2];
  // BASE_ADDR is aligned to the window size, so range check is a tag compare.
  assign addr_ok  = (I_MEM_HADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign size_ok  = (I_MEM_HSIZE <= HSIZE_WORD);

  always_comb begin
    align_ok = 1'b1;
    if (I_MEM_HSIZE == HSIZE_HALF)      align_ok = !I_MEM_HADDR[0];
    else if (I_MEM_HSIZE == HSIZE_WORD) align_ok = (I_MEM_HADDR[1:0] == 2'b00);
  end

  assign req_err = !(addr_ok && size_ok && align_ok);

`ifdef AHB_IMG_MEM_SEQ_FAST_EN
  logic prev_ok;
  always_ff @(posedge I_HCLK) begin
    if (I_HRESET)    prev_ok <= 1'b0;
    else if (accept) prev_ok <= !req_err;
  end
  assign skip_wait = prev_ok && (I_MEM_HTRANS == HTRANS_SEQ);
`else
  assign skip_wait = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    case (state)
      ST_WAIT: begin
        cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) state_nxt = ST_DATA;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
    // accept is only possible in IDLE/DATA/ERR2, so it overrides the above.
    if (accept) begin
      if (req_err) begin
        state_nxt = ST_ERR1;
      end else if (WAIT_STATES == 0 || skip_wait) begin
        state_nxt = ST_DATA;
      end else begin
        state_nxt = ST_WAIT;
        cnt_nxt   = WAIT_INIT;
      end
    end
  end

  assign O_MEM_HREADY = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign O_MEM_HRESP  = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  // Write commits on the edge that ends DATA; reset on that edge cancels it.
  assign wr_be = (state == ST_DATA && pend_write && !I_HRESET) ? pend_be : 4'b0000;

  // The fetch happens on the edge entering DATA: from the bus when DATA is
  // entered straight from the address phase, otherwise from the pending beat.
  assign fetch_from_bus = accept && (state_nxt == ST_DATA);
  assign rd_addr        = fetch_from_bus ? bus_word : pend_addr;
  assign rd_is_read     = fetch_from_bus ? !I_MEM_HWRITE : !pend_write;
  assign rd_en          = !I_HRESET && (state_nxt == ST_DATA) && rd_is_read;

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      pend_write <= 1'b0;
      pend_addr  <= '0;
      pend_be    <= 4'b0000;
      fwd_mask   <= 4'b0000;
      fwd_data   <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      if (accept) begin
        pend_write <= I_MEM_HWRITE && !req_err;
        pend_addr  <= bus_word;
        pend_be    <= byte_enable(I_MEM_HSIZE, I_MEM_HADDR[1:0]);
      end
      if (rd_en) begin
        // The array returns pre-write data, so remember which lanes to overlay.
        fwd_mask <= (wr_be != 4'b0000 && pend_addr == rd_addr) ? wr_be : 4'b0000;
        fwd_data <= I_MEM_HWDATA;
      end
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign O_MEM_HRDATA[8*b +: 8] = fwd_mask[b] ? fwd_data[8*b +: 8] : arr_rdata[8*b +: 8];
  end

  ahb_img_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (I_HCLK),
    .rst     (I_HRESET),
    .wr_addr (pend_addr),
    .wr_be   (wr_be),
    .wr_data (I_MEM_HWDATA),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (arr_rdata)
  );

endmodule
